// File: rtl/frame_buf_pkg.sv
// rtl/frame_buf_pkg.sv - shared constants, FSM encoding and YCbCr unpacking for the frame buffer
package frame_buf_pkg;
  localparam int LOGSIZE    = 19;
  localparam int WIDTH      = 24;
  localparam int NPIXELS    = 307200;
  localparam int MAX_WR_RUN = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] p1;
    logic [WIDTH-1:0] p0;
  } pix_pair_t;

  // Camera word {Cb, Y0, Cr, Y1} carries two pixels sharing one chroma pair
  function automatic pix_pair_t unpack_ycbcr(input logic [31:0] word);
    pix_pair_t pp;
    pp.p0 = {word[23:16], word[31:24], word[15:8]};
    pp.p1 = {word[7:0],   word[31:24], word[15:8]};
    return pp;
  endfunction
endpackage

// File: rtl/vsync_sync.sv
// rtl/vsync_sync.sv - two-flop vsync synchronizer with rising-edge pulse
module vsync_sync (
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  output logic rise
);
  logic s1, s2, s3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= vsync;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
endmodule

// File: rtl/frame_buf_arbiter.sv
// rtl/frame_buf_arbiter.sv - shares the frame-buffer BRAM between camera capture and pixel reader
module frame_buf_arbiter #(
  parameter int LOGSIZE    = frame_buf_pkg::LOGSIZE,
  parameter int WIDTH      = frame_buf_pkg::WIDTH,
  parameter int NPIXELS    = frame_buf_pkg::NPIXELS,
  parameter int MAX_WR_RUN = frame_buf_pkg::MAX_WR_RUN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vsync,
  input  logic               cam_valid,
  input  logic [31:0]        cam_data,
  output logic               cam_ready,
  input  logic               rd_req,
  input  logic [LOGSIZE-1:0] rd_addr,
  output logic               rd_grant,
  output logic               rd_valid,
  output logic [WIDTH-1:0]   rd_data,
  output logic [LOGSIZE-1:0] bram_addr,
  output logic [WIDTH-1:0]   bram_din,
  output logic               bram_we,
  input  logic [WIDTH-1:0]   bram_dout,
  output logic               frame_done,
  output logic               overflow,
  output logic               frame_abort
);
  import frame_buf_pkg::*;

  localparam int RUN_W = $clog2(MAX_WR_RUN + 1);

  state_t             state, state_next;
  logic               rise;
  logic [LOGSIZE-1:0] wr_addr;
  logic [31:0]        word;
  logic               full, phase;
  logic [RUN_W-1:0]   run_cnt;
  logic               rd_p1;
  logic               wr_pend, wr_slot, last_slot;
  pix_pair_t          pix;

  vsync_sync u_vsync_sync (
    .clk   (clk),
    .reset (reset),
    .vsync (vsync),
    .rise  (rise)
  );

  // A vsync edge flushes the holding register, so it never competes for the slot
  assign wr_pend    = (state == CAPTURE) && full && !rise;
  assign rd_grant   = rd_req && (!wr_pend || run_cnt == RUN_W'(MAX_WR_RUN));
  assign wr_slot    = wr_pend && !rd_grant;
  assign last_slot  = wr_slot && (wr_addr == LOGSIZE'(NPIXELS - 1));
  assign pix        = unpack_ycbcr(word);
  assign cam_ready  = !full;
  assign frame_done = (state == DONE);
  assign rd_data    = rd_valid ? bram_dout : '0;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rise) state_next = CAPTURE;
      CAPTURE: if (rise) state_next = CAPTURE;
               else if (last_slot) state_next = DONE;
      DONE:    if (rise) state_next = CAPTURE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      wr_addr     <= '0;
      word        <= '0;
      full        <= 1'b0;
      phase       <= 1'b0;
      overflow    <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      state       <= state_next;
      frame_abort <= rise && (state == CAPTURE);
      if (rise) begin
        wr_addr  <= '0;
        phase    <= 1'b0;
        overflow <= 1'b0;
        full     <= cam_valid;
        if (cam_valid) word <= cam_data;
      end else if (state == CAPTURE) begin
        if (wr_slot) begin
          wr_addr <= wr_addr + 1'b1;
          phase   <= ~phase;
        end
        // The pixel-1 slot frees the register in time to take a word arriving alongside it
        if (last_slot) begin
          full <= 1'b0;
        end else if (cam_valid && (!full || (wr_slot && phase))) begin
          word  <= cam_data;
          full  <= 1'b1;
          phase <= 1'b0;
        end else if (cam_valid) begin
          overflow <= 1'b1;
        end else if (wr_slot && phase) begin
          full <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_cnt   <= '0;
      bram_addr <= '0;
      bram_din  <= '0;
      bram_we   <= 1'b0;
      rd_p1     <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      rd_p1    <= rd_grant;
      rd_valid <= rd_p1;
      if (!rd_req || rd_grant) run_cnt <= '0;
      else if (wr_slot) run_cnt <= run_cnt + 1'b1;
      bram_we <= wr_slot;
      if (wr_slot) begin
        bram_addr <= wr_addr;
        bram_din  <= phase ? pix.p1 : pix.p0;
      end else if (rd_grant) begin
        bram_addr <= rd_addr;
      end
    end
  end
endmodule

// File: doc/frame_buf_arbiter.md
Name: frame_buf_arbiter

Overview:
- Owns the single-port frame-buffer BRAM (2^LOGSIZE x WIDTH) and shares it between two requesters:
  - the camera pixel stream (writer), which delivers one 32-bit YCbCr 4:2:2 word = 2 pixels;
  - a downstream reader (laser-spot scanner / display), which issues single-pixel reads.
- Sequences frame capture from vsync and flags completion after NPIXELS pixels.
- Sits between the camera capture front-end and the BRAM instance, and drives the BRAM addr/din/we directly.

Parameters:
LOGSIZE, 19, BRAM address width
WIDTH, 24, pixel width {Y,Cb,Cr}
NPIXELS, 307200, pixels per frame (640x480)
MAX_WR_RUN, 3, maximum consecutive write slots while a read is pending

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
vsync  in  1  camera frame sync; rising edge starts a frame
cam_valid  in  1  cam_data valid this cycle (one-cycle strobe; camera cannot stall)
cam_data  in  32  {Cb[31:24], Y0[23:16], Cr[15:8], Y1[7:0]}
cam_ready  out  1  holding register empty
rd_req  in  1  reader request; hold until rd_grant
rd_addr  in  LOGSIZE  read pixel address
rd_grant  out  1  request accepted this cycle
rd_valid  out  1  rd_data valid
rd_data  out  WIDTH  read pixel
bram_addr  out  LOGSIZE  registered BRAM address
bram_din  out  WIDTH  registered write data
bram_we  out  1  registered write enable (active-high)
bram_dout  in  WIDTH  BRAM read data; synchronous, valid 1 cycle after bram_addr
frame_done  out  1  level signal: frame fully written
overflow  out  1  sticky flag: camera word dropped
frame_abort  out  1  1-cycle pulse: vsync arrived mid-capture

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; write address=0; holding register empty; run counter=0.
  - Outputs at reset: cam_ready=1; rd_grant=0; rd_valid=0; rd_data=0; bram_addr=0; bram_din=0; bram_we=0; frame_done=0; overflow=0; frame_abort=0.
- vsync is synchronized through 2 flops; rising-edge detect is taken on the synchronized signal.
- States:
  - IDLE: waiting for a vsync rising edge; go to CAPTURE.
  - CAPTURE: pixels are written.
  - DONE: frame_done=1; the next vsync rising edge goes to CAPTURE.
- Entering CAPTURE:
  - write address=0; holding register flushed; overflow cleared; frame_done cleared.
- Camera input and holding register:
  - cam_valid in IDLE or DONE: word discarded; overflow not set.
  - cam_valid in CAPTURE with register empty: latch the word and set phase=0.
    - Pixel 0 = {cam_data[23:16], cam_data[31:24], cam_data[15:8]}.
    - Pixel 1 = {cam_data[7:0], cam_data[31:24], cam_data[15:8]}.
  - cam_valid in CAPTURE with register full: word dropped; overflow=1.
  - The register empties in the same cycle that the pixel-1 write slot is granted, and can accept a new word in that same cycle.
- Slot arbitration (one BRAM access per cycle):
  - Write pending = CAPTURE and register full.
  - Read is granted when rd_req=1 and (no write pending, or run counter == MAX_WR_RUN).
  - Otherwise a pending write takes the slot.
  - Run counter increments on each write slot taken while rd_req=1; it resets to 0 on a read grant or when rd_req=0.
- Write slot:
  - bram_addr <= write address; bram_din <= pixel[phase]; bram_we <= 1.
  - Write address increments by 1; phase toggles.
- Read slot:
  - rd_grant=1 (combinational) in the grant cycle.
  - bram_addr <= rd_addr; bram_we <= 0.
  - rd_valid=1 and rd_data=bram_dout exactly 2 cycles after the rd_grant cycle.
- Idle slot: bram_we <= 0; bram_addr holds its value.
- Last pixel:
  - The write slot with address NPIXELS-1 moves the state to DONE, and frame_done=1 from the next cycle.
  - Any remaining pixel 1 is discarded; the register is flushed.
- vsync rising edge in CAPTURE:
  - frame_abort pulses for 1 cycle.
  - Capture restarts at address 0; the register is flushed; overflow is cleared.
- Simultaneous events:
  - vsync edge and a cam_valid in the same cycle: the word is latched as the first word of the new frame.
  - Reads are served in every state and are unaffected by vsync.
- Width rules: the address is compared against NPIXELS-1 exactly, so no writes occur beyond NPIXELS-1; there is no wrap.

Decomposition:
- Package frame_buf_pkg holds:
  - LOGSIZE, WIDTH, NPIXELS;
  - state encoding IDLE/CAPTURE/DONE;
  - a function that unpacks a YCbCr word into its two pixels.
- Sub-module vsync_sync: 2-flop synchronizer plus rising-edge pulse. The arbiter FSM stays in the top module.

Test Plan:
1. Reset, vsync edge, then 4 cam words with 4-cycle spacing and no reads -> bram writes at addr 0..7; pixel 0 of 0xAA11BB22 is 0x11AABB, pixel 1 is 0x22AABB.
2. Full frame of 153600 words -> last write at addr 307199; frame_done=1 the next cycle; no writes after; overflow=0.
3. rd_req held constantly with back-to-back cam words -> at most 3 consecutive writes before each rd_grant; rd_valid 2 cycles after grant with the preloaded data.
4. cam_valid on 2 consecutive cycles while a read holds the slot -> second word dropped; overflow=1; it clears on the next vsync edge.
5. vsync edge after 100 pixels -> frame_abort pulses; next write at addr 0; frame_done stays 0.
6. reset asserted mid-capture with the register full -> all outputs at reset values asynchronously; no further writes until a new vsync edge.
